// File: rtl/sarray_feeder.sv
// Systolic-array edge feeder: pairs A/B beats, skews them diagonally across
// H lanes (lane i delayed i+1 cycles) and pulses done once the deepest lane drains.
module sarray_feeder #(
    parameter int unsigned H  = 64,
    parameter int unsigned DW = 8,
    parameter int unsigned CW = 16,
    parameter int unsigned PW = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [CW-1:0]     cmd_k_i,
    input  logic              cmd_type_i,
    input  logic [PW-1:0]     cmd_precision_i,
    input  logic              cmd_acc_i,
    input  logic              a_valid_i,
    output logic              a_ready_o,
    input  logic [H*DW-1:0]   a_data_i,
    input  logic              b_valid_i,
    output logic              b_ready_o,
    input  logic [H*DW-1:0]   b_data_i,
    output logic [H-1:0]      left_in_valid_o,
    output logic [CW*H-1:0]   left_in_cnt_o,
    output logic [H-1:0]      left_in_type_o,
    output logic [PW*H-1:0]   left_in_precision_o,
    output logic [H:0]        left_in_acc_o,
    output logic [H*DW-1:0]   left_in_data_o,
    output logic [H-1:0]      top_in_valid_o,
    output logic [CW*H-1:0]   top_in_cnt_o,
    output logic [H*DW-1:0]   top_in_data_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int unsigned FW = (H > 1) ? $clog2(H) : 1;
    // One delay-line stage: {valid, cnt, a slice, b slice}
    localparam int unsigned SW = 1 + CW + 2 * DW;

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        FLUSH
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] k_q, k_d;
    logic [CW-1:0] beat_q, beat_d;
    logic          type_q, type_d;
    logic [PW-1:0] prec_q, prec_d;
    logic          acc_q, acc_d;
    logic [FW-1:0] flush_q, flush_d;
    logic          done_q, done_d;
    logic          issue_c;

    assign issue_c     = (state_q == FEED) && a_valid_i && b_valid_i;
    assign a_ready_o   = issue_c;
    assign b_ready_o   = issue_c;
    assign cmd_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign done_o      = done_q;

    // State, latched command fields and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            beat_q  <= '0;
            type_q  <= 1'b0;
            prec_q  <= '0;
            acc_q   <= 1'b0;
            flush_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            beat_q  <= beat_d;
            type_q  <= type_d;
            prec_q  <= prec_d;
            acc_q   <= acc_d;
            flush_q <= flush_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: accept command, count issued beats, then drain H cycles
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        beat_d  = beat_q;
        type_d  = type_q;
        prec_d  = prec_q;
        acc_d   = acc_q;
        flush_d = flush_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    k_d     = cmd_k_i;
                    type_d  = cmd_type_i;
                    prec_d  = cmd_precision_i;
                    acc_d   = cmd_acc_i;
                    beat_d  = '0;
                    flush_d = '0;
                    state_d = (cmd_k_i == '0) ? FLUSH : FEED;
                end
            end
            FEED: begin
                if (issue_c) begin
                    beat_d = beat_q + CW'(1);
                    if (beat_q == k_q - CW'(1)) begin
                        state_d = FLUSH;
                        flush_d = '0;
                    end
                end
            end
            FLUSH: begin
                if (flush_q == FW'(H - 1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    flush_d = flush_q + FW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign left_in_acc_o[H] = acc_q & busy_o;

    for (genvar i = 0; i < H; i++) begin : g_lane
        logic [i:0][SW-1:0] sr;
        logic [SW-1:0]      stage_in;
        logic [SW-1:0]      tail;
        logic               lv;

        assign stage_in = issue_c ? {1'b1, beat_q, a_data_i[i*DW +: DW], b_data_i[i*DW +: DW]}
                                  : '0;

        if (i == 0) begin : g_first
            // Single-stage delay line for lane 0
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) sr <= '0;
                else        sr <= stage_in;
            end
        end else begin : g_rest
            // Free-running shift register of depth i+1
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) sr <= '0;
                else        sr <= {sr[i-1:0], stage_in};
            end
        end

        assign tail = sr[i];
        assign lv   = tail[SW-1];

        assign left_in_valid_o[i]                  = lv;
        assign top_in_valid_o[i]                   = lv;
        assign left_in_cnt_o[i*CW +: CW]           = tail[2*DW +: CW];
        assign top_in_cnt_o[i*CW +: CW]            = tail[2*DW +: CW];
        assign left_in_data_o[i*DW +: DW]          = tail[DW +: DW];
        assign top_in_data_o[i*DW +: DW]           = tail[0 +: DW];
        assign left_in_type_o[i]                   = lv & type_q;
        assign left_in_precision_o[i*PW +: PW]     = {PW{lv}} & prec_q;
        assign left_in_acc_o[i]                    = lv & acc_q;
    end

endmodule

// File: tb/tb_sarray_feeder.sv
// Randomized scoreboard bench for sarray_feeder (H=4).
module tb_sarray_feeder;

    localparam int H  = 4;
    localparam int DW = 8;
    localparam int CW = 8;
    localparam int PW = 3;

    logic              clk;
    logic              rst_n;
    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic [CW-1:0]     cmd_k_i;
    logic              cmd_type_i;
    logic [PW-1:0]     cmd_precision_i;
    logic              cmd_acc_i;
    logic              a_valid_i;
    logic              a_ready_o;
    logic [H*DW-1:0]   a_data_i;
    logic              b_valid_i;
    logic              b_ready_o;
    logic [H*DW-1:0]   b_data_i;
    logic [H-1:0]      left_in_valid_o;
    logic [CW*H-1:0]   left_in_cnt_o;
    logic [H-1:0]      left_in_type_o;
    logic [PW*H-1:0]   left_in_precision_o;
    logic [H:0]        left_in_acc_o;
    logic [H*DW-1:0]   left_in_data_o;
    logic [H-1:0]      top_in_valid_o;
    logic [CW*H-1:0]   top_in_cnt_o;
    logic [H*DW-1:0]   top_in_data_o;
    logic              busy_o;
    logic              done_o;

    sarray_feeder #(.H(H), .DW(DW), .CW(CW), .PW(PW)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .cmd_valid_i         (cmd_valid_i),
        .cmd_ready_o         (cmd_ready_o),
        .cmd_k_i             (cmd_k_i),
        .cmd_type_i          (cmd_type_i),
        .cmd_precision_i     (cmd_precision_i),
        .cmd_acc_i           (cmd_acc_i),
        .a_valid_i           (a_valid_i),
        .a_ready_o           (a_ready_o),
        .a_data_i            (a_data_i),
        .b_valid_i           (b_valid_i),
        .b_ready_o           (b_ready_o),
        .b_data_i            (b_data_i),
        .left_in_valid_o     (left_in_valid_o),
        .left_in_cnt_o       (left_in_cnt_o),
        .left_in_type_o      (left_in_type_o),
        .left_in_precision_o (left_in_precision_o),
        .left_in_acc_o       (left_in_acc_o),
        .left_in_data_o      (left_in_data_o),
        .top_in_valid_o      (top_in_valid_o),
        .top_in_cnt_o        (top_in_cnt_o),
        .top_in_data_o       (top_in_data_o),
        .busy_o              (busy_o),
        .done_o              (done_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected lane beat: the clock-edge number after which it must be visible
    typedef struct {
        int unsigned   cyc;
        logic [CW-1:0] cnt;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          ty;
        logic [PW-1:0] pr;
        logic          ac;
    } beat_t;

    typedef enum int {P_IDLE, P_FEED, P_WAIT} ph_t;

    beat_t         lq [H][$];
    int unsigned   done_q [$];
    ph_t           ph = P_IDLE;
    int unsigned   cyc = 0;
    int unsigned   done_edge = 0;
    int            m_k = 0;
    int            m_cnt = 0;
    logic          m_type = 1'b0;
    logic [PW-1:0] m_prec = '0;
    logic          m_acc = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    int a_prob = 100;
    int b_prob = 100;
    bit b_hold = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", nm, act, exp, cyc, $time);
        end
    endtask

    // Reference model: command accept, paired issue while feeding, done H edges after last issue
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int i = 0; i < H; i++) lq[i].delete();
                done_q.delete();
                ph     = P_IDLE;
                m_type = 1'b0;
                m_prec = '0;
                m_acc  = 1'b0;
            end else begin
                cyc++;
                case (ph)
                    P_IDLE: begin
                        if (cmd_valid_i) begin
                            m_k    = int'(cmd_k_i);
                            m_type = cmd_type_i;
                            m_prec = cmd_precision_i;
                            m_acc  = cmd_acc_i;
                            m_cnt  = 0;
                            if (m_k == 0) begin
                                done_edge = cyc + H;
                                done_q.push_back(done_edge);
                                ph = P_WAIT;
                            end else begin
                                ph = P_FEED;
                            end
                        end
                    end
                    P_FEED: begin
                        if (a_valid_i && b_valid_i) begin
                            for (int i = 0; i < H; i++) begin
                                beat_t e;
                                e.cyc = cyc + i;
                                e.cnt = CW'(m_cnt);
                                e.a   = a_data_i[i*DW +: DW];
                                e.b   = b_data_i[i*DW +: DW];
                                e.ty  = m_type;
                                e.pr  = m_prec;
                                e.ac  = m_acc;
                                lq[i].push_back(e);
                            end
                            m_cnt++;
                            if (m_cnt == m_k) begin
                                done_edge = cyc + H;
                                done_q.push_back(done_edge);
                                ph = P_WAIT;
                            end
                        end
                    end
                    default: begin
                        if (cyc == done_edge) ph = P_IDLE;
                    end
                endcase
            end
        end
    end

    // Monitor: compare every DUT output against the model on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            begin
                bit exp_d;
                chk("cmd_ready", 64'(cmd_ready_o), 64'(ph == P_IDLE));
                chk("busy", 64'(busy_o), 64'(ph != P_IDLE));
                chk("a_ready", 64'(a_ready_o), 64'(ph == P_FEED && a_valid_i && b_valid_i));
                chk("b_ready", 64'(b_ready_o), 64'(ph == P_FEED && a_valid_i && b_valid_i));
                chk("acc_busy", 64'(left_in_acc_o[H]), 64'((ph != P_IDLE) && m_acc));
                exp_d = (done_q.size() > 0) && (done_q[0] == cyc);
                if (exp_d) void'(done_q.pop_front());
                chk("done", 64'(done_o), 64'(exp_d));
                for (int i = 0; i < H; i++) begin
                    bit exp_v;
                    exp_v = (lq[i].size() > 0) && (lq[i][0].cyc == cyc);
                    chk($sformatf("lane%0d_left_valid", i), 64'(left_in_valid_o[i]), 64'(exp_v));
                    chk($sformatf("lane%0d_top_valid", i), 64'(top_in_valid_o[i]), 64'(exp_v));
                    if (exp_v) begin
                        beat_t e;
                        e = lq[i].pop_front();
                        chk($sformatf("lane%0d_left_cnt", i), 64'(left_in_cnt_o[i*CW +: CW]), 64'(e.cnt));
                        chk($sformatf("lane%0d_top_cnt", i), 64'(top_in_cnt_o[i*CW +: CW]), 64'(e.cnt));
                        chk($sformatf("lane%0d_a_data", i), 64'(left_in_data_o[i*DW +: DW]), 64'(e.a));
                        chk($sformatf("lane%0d_b_data", i), 64'(top_in_data_o[i*DW +: DW]), 64'(e.b));
                        chk($sformatf("lane%0d_fields", i),
                            64'({left_in_type_o[i], left_in_precision_o[i*PW +: PW], left_in_acc_o[i]}),
                            64'({e.ty, e.pr, e.ac}));
                    end else begin
                        chk($sformatf("lane%0d_bubble", i),
                            64'({left_in_cnt_o[i*CW +: CW], top_in_cnt_o[i*CW +: CW],
                                 left_in_data_o[i*DW +: DW], top_in_data_o[i*DW +: DW],
                                 left_in_type_o[i], left_in_precision_o[i*PW +: PW], left_in_acc_o[i]}),
                            64'(0));
                    end
                end
            end
        end
    end

    // Advance one clock; reports the command handshake and done seen in the cycle just ended
    task automatic tick(output bit hs, output bit dn);
        hs = cmd_valid_i && cmd_ready_o;
        dn = done_o;
        @(posedge clk);
        #1;
        a_valid_i = ($urandom_range(0, 99) < a_prob);
        b_valid_i = ($urandom_range(0, 99) < b_prob) && !b_hold;
        a_data_i  = H*DW'($urandom);
        b_data_i  = H*DW'($urandom);
    endtask

    task automatic send_cmd(input int k, input bit ty, input int pr, input bit ac, output bit was_done);
        bit got;
        got             = 1'b0;
        was_done        = 1'b0;
        cmd_k_i         = CW'(k);
        cmd_type_i      = ty;
        cmd_precision_i = PW'(pr);
        cmd_acc_i       = ac;
        cmd_valid_i     = 1'b1;
        for (int w = 0; w < 3000 && !got; w++) tick(got, was_done);
        chk("cmd_accept_timeout", 64'(got), 64'(1));
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        bit hs;
        bit dn;
        bit ok;
        ok = 1'b0;
        for (int w = 0; w < 3000 && !ok; w++) begin
            if (cmd_ready_o && !busy_o) ok = 1'b1;
            else tick(hs, dn);
        end
        chk("idle_timeout", 64'(ok), 64'(1));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valids"}, 64'({left_in_valid_o, top_in_valid_o}), 64'(0));
        chk({tag, "_cnts"}, 64'({left_in_cnt_o, top_in_cnt_o}), 64'(0));
        chk({tag, "_fields"}, 64'({left_in_type_o, left_in_precision_o, left_in_acc_o}), 64'(0));
        chk({tag, "_data"}, 64'({left_in_data_o, top_in_data_o}), 64'(0));
        chk({tag, "_cmd_ready"}, 64'(cmd_ready_o), 64'(1));
        chk({tag, "_ab_ready"}, 64'({a_ready_o, b_ready_o}), 64'(0));
        chk({tag, "_busy"}, 64'(busy_o), 64'(0));
        chk({tag, "_done"}, 64'(done_o), 64'(0));
    endtask

    initial begin
        bit wd;
        bit hs;
        bit dn;
        rst_n           = 1'b0;
        cmd_valid_i     = 1'b0;
        cmd_k_i         = '0;
        cmd_type_i      = 1'b0;
        cmd_precision_i = '0;
        cmd_acc_i       = 1'b0;
        a_valid_i       = 1'b0;
        b_valid_i       = 1'b0;
        a_data_i        = '0;
        b_data_i        = '0;
        #1;
        check_reset_outputs("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Continuous feed, K=3
        a_prob = 100;
        b_prob = 100;
        send_cmd(3, 1'b1, 5, 1'b1, wd);
        wait_idle();

        // B-side gap of two cycles between beats, K=2
        send_cmd(2, 1'b0, 2, 1'b0, wd);
        b_hold = 1'b1;
        tick(hs, dn);
        tick(hs, dn);
        b_hold = 1'b0;
        tick(hs, dn);
        wait_idle();

        // Empty command
        send_cmd(0, 1'b1, 3, 1'b1, wd);
        wait_idle();

        // Second command held while busy, accepted in the done cycle
        send_cmd(2, 1'b1, 5, 1'b1, wd);
        send_cmd(3, 1'b0, 2, 1'b0, wd);
        chk("overlap_accept_in_done", 64'(wd), 64'(1));
        wait_idle();

        // Reset in the middle of feeding K=8
        send_cmd(8, 1'b1, 7, 1'b1, wd);
        tick(hs, dn);
        tick(hs, dn);
        tick(hs, dn);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_cmd(1, 1'b0, 1, 1'b1, wd);
        wait_idle();

        // Largest beat count
        a_prob = 85;
        b_prob = 85;
        send_cmd((1 << CW) - 1, 1'b1, 6, 1'b0, wd);
        wait_idle();

        // Random commands with random source gaps and spacing
        for (int n = 0; n < 30; n++) begin
            a_prob = int'($urandom_range(40, 100));
            b_prob = int'($urandom_range(40, 100));
            send_cmd(int'($urandom_range(0, 9)), 1'($urandom), int'($urandom_range(0, 7)),
                     1'($urandom), wd);
            for (int g = 0, lim = int'($urandom_range(0, 3)); g < lim; g++) tick(hs, dn);
        end
        wait_idle();
        for (int g = 0; g < H + 3; g++) tick(hs, dn);

        begin
            int left;
            left = done_q.size();
            for (int i = 0; i < H; i++) left += lq[i].size();
            chk("drain_pending", 64'(left), 64'(0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sarray_feeder.md
# sarray_feeder

Transmit-side front end of the systolic array: accepts a matrix-multiply command plus paired A-row and B-column beat streams, and drives the array's left and top edge inputs with the diagonal skew the PE mesh expects. Lane i of each edge carries every beat delayed by i+1 cycles from its issue, tagged with its beat index. The block sits between the tensor load buffers and `sarray`. It signals completion once the last beat has left the most-delayed lane.

## Interface
Parameters:
- `H`, default `SARRAY_H` (64): number of lanes per edge.
- `DW`, default `PE_INPUT_DATA_WIDTH`: data width of one lane.
- `CW`, default `TMMA_CNT_WIDTH`: width of the beat count and beat index.
- `PW`, default `TMMA_PRECISION_WIDTH`: width of the precision code.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `cmd_valid_i` / `cmd_ready_o`  in/out  1  command handshake.
- `cmd_k_i`  in  CW  number of beats K.
- `cmd_type_i`  in  1  left data type.
- `cmd_precision_i`  in  PW  precision code.
- `cmd_acc_i`  in  1  accumulate flag.
- `a_valid_i` / `a_ready_o`  in/out  1  A-stream handshake.
- `a_data_i`  in  H*DW  one A beat; lane i is `[i*DW +: DW]`.
- `b_valid_i` / `b_ready_o`  in/out  1  B-stream handshake.
- `b_data_i`  in  H*DW  one B beat.
- `left_in_valid_o`  out  H  per-lane skewed valid.
- `left_in_cnt_o`  out  CW*H  per-lane beat index.
- `left_in_type_o`  out  H  latched type, gated by lane valid.
- `left_in_precision_o`  out  PW*H  latched precision, gated by lane valid.
- `left_in_acc_o`  out  H+1  bits [H-1:0] = latched acc gated by lane valid; bit H = latched acc while busy.
- `left_in_data_o`  out  H*DW  skewed A data.
- `top_in_valid_o`  out  H  per-lane skewed valid.
- `top_in_cnt_o`  out  CW*H  per-lane beat index.
- `top_in_data_o`  out  H*DW  skewed B data.
- `busy_o`  out  1  high in FEED and FLUSH.
- `done_o`  out  1  one-cycle completion pulse.

## Operation
State machine: IDLE, FEED, FLUSH.

- **IDLE**
  - `cmd_ready_o` = 1.
  - On command accept, latch K, type, precision and acc, and clear the beat counter.
  - K ≥ 1: go to FEED.
  - K = 0: go directly to FLUSH.
- **FEED**
  - Issue fires when `a_valid_i && b_valid_i`.
  - `a_ready_o = b_ready_o = FEED && a_valid_i && b_valid_i`, so A and B are always consumed together.
  - On issue, stage 0 of every lane's delay line loads valid = 1, cnt = beat counter, and that lane's A/B slice. The beat counter then increments.
  - In a cycle without issue, stage 0 loads valid = 0, and cnt/data are 0.
  - The issue of beat K-1 moves the block to FLUSH.
- **FLUSH**
  - Stage-0 inserts are bubbles.
  - The flush counter counts 0..H-1; at H-1 the block moves to IDLE and registers `done_o`.
  - For K = 0 the same H-cycle FLUSH runs with no valid beats.
- **Skew**
  - Lane i is a shift register of depth i+1, clocked every cycle with no stall.
  - Lane outputs come directly from the final stage.
  - Left and top lanes with the same index carry identical timing and cnt.
- **Gating and stability**
  - type, precision and acc[i] are 0 whenever lane i's valid is 0.
  - The latched command fields stay stable until the next command accept.
- **Width rules**
  - The beat counter is CW bits.
  - K up to 2^CW−1 is legal; cnt never wraps within a command.
- **Reset**, asynchronous and including mid-command:
  - All delay stages clear.
  - The state machine returns to IDLE.
  - Every output is 0 except `cmd_ready_o` = 1.
  - Partial beats are discarded and no `done_o` is produced.

## Timing
- Issue handshake at cycle t: lane i shows that beat at cycle t+i+1.
- Last issue at cycle t: lane H-1 shows the last beat at t+H; `done_o` = 1 at t+H+1. In that same cycle the block is in IDLE with `cmd_ready_o` = 1, and `busy_o` = 0.
- Back-to-back issues produce back-to-back valids on every lane. Source gaps reproduce as identical gaps on every lane.
- A command arriving while busy stalls; no command is accepted before `done_o`.
- A command accepted in the `done_o` cycle is legal; its first beat can issue the next cycle.
- Beats offered in IDLE or FLUSH are not consumed: `a_ready_o` = `b_ready_o` = 0.

## Test plan
- **Reset:** with H=4, assert `rst_n`=0 → all valids 0, `cmd_ready_o`=1, `done_o`=0, `busy_o`=0.
- **Basic skew:** K=3, A and B valid continuously from cycle 1 after the command → lane i shows cnt 0,1,2 at cycles i+2..i+4; data matches the lane slices; `done_o` at cycle 8.
- **Source gap:** K=2, `b_valid_i` low for 2 cycles between beats → every lane shows valid,0,0,valid; A is not consumed during the gap; cnt = 0 then 1.
- **K=0:** command accepted → no valid on any lane, `done_o` exactly H+1 cycles after accept, `busy_o` high for H cycles.
- **Overlapped command:** second command held during busy → accepted in the `done_o` cycle; its first lane-0 beat can appear 2 cycles later; type/precision switch cleanly.
- **Mid-operation reset:** `rst_n` pulsed low during FEED of K=8 → outputs immediately 0, no `done_o`; a fresh K=1 command then completes normally.
